// File: rtl/systolic_ctrl.sv
// systolic_ctrl: job sequencer for a ROWS x COLS weight-stationary systolic array.
//
// Per job it loads the stationary weights row by row (skipped on request), streams
// num_vec input vectors and produces the diagonal I_en skew plus per-column capture
// strobes with vector indices for the bottom-row partial sums. Only enables and
// addresses are generated; the data skew registers live outside this block.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         job request, sampled only while idle
//   skip_wload    with start: 1 = reuse stationary weights
//   num_vec       with start: number of input vectors (0 = empty job)
//   busy, done    job in progress / one-cycle completion pulse
//   w_rd_en       weight buffer read strobe (1-cycle read latency)
//   w_rd_addr     weight buffer row address, counts ROWS-1 down to 0
//   w_load_en     W_en of all PEs (w_rd_en delayed one cycle)
//   i_rd_en       input buffer read strobe (1-cycle read latency)
//   i_rd_addr     input vector address, counts 0 .. num_vec-1
//   i_row_en      bit r = I_en of row r (i_rd_en delayed 1+r)
//   o_valid       bit c = bottom P_out of column c valid (i_rd_en delayed 1+ROWS+c)
//   o_vec_idx     slice c = vector index belonging to o_valid[c], 0 when not valid
module systolic_ctrl #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int VEC_W = 16,
    localparam int AW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  skip_wload,
    input  logic [VEC_W-1:0]      num_vec,
    output logic                  busy,
    output logic                  done,
    output logic                  w_rd_en,
    output logic [AW-1:0]         w_rd_addr,
    output logic                  w_load_en,
    output logic                  i_rd_en,
    output logic [VEC_W-1:0]      i_rd_addr,
    output logic [ROWS-1:0]       i_row_en,
    output logic [COLS-1:0]       o_valid,
    output logic [COLS*VEC_W-1:0] o_vec_idx
);

    // Delay line spans the row skew plus the column skew of the bottom row.
    localparam int DEPTH = ROWS + COLS;
    localparam int DW    = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StStream,
        StDrain,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   num_vec_q, num_vec_d;
    logic [AW-1:0]      w_addr_q, w_addr_d;
    logic [VEC_W-1:0]   i_addr_q, i_addr_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic               busy_q, done_q, w_rd_en_q, w_load_en_q, i_rd_en_q;
    logic [DEPTH-1:0]   en_q;
    logic [VEC_W-1:0]   idx_q [DEPTH];

    // Next-state logic; counters are derived from the next state so that every
    // output comes straight from a flop.
    always_comb begin
        state_d   = state_q;
        num_vec_d = num_vec_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    num_vec_d = num_vec;
                    if (num_vec == '0) begin
                        state_d = StDone;
                    end else if (skip_wload) begin
                        state_d = StStream;
                    end else begin
                        state_d = StLoadW;
                    end
                end
            end
            StLoadW: begin
                if (w_addr_q == '0) state_d = StStream;
            end
            StStream: begin
                if (i_addr_q == num_vec_q - VEC_W'(1)) state_d = StDrain;
            end
            StDrain: begin
                // Last o_valid[COLS-1] is emitted DEPTH cycles after the last read.
                if (drain_q == DW'(DEPTH - 1)) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        w_addr_d = '0;
        if (state_d == StLoadW) begin
            w_addr_d = (state_q == StLoadW) ? w_addr_q - AW'(1) : AW'(ROWS - 1);
        end
        i_addr_d = '0;
        if (state_d == StStream && state_q == StStream) begin
            i_addr_d = i_addr_q + VEC_W'(1);
        end
        drain_d = '0;
        if (state_d == StDrain && state_q == StDrain) begin
            drain_d = drain_q + DW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            num_vec_q   <= '0;
            w_addr_q    <= '0;
            i_addr_q    <= '0;
            drain_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            w_rd_en_q   <= 1'b0;
            w_load_en_q <= 1'b0;
            i_rd_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_vec_q   <= num_vec_d;
            w_addr_q    <= w_addr_d;
            i_addr_q    <= i_addr_d;
            drain_q     <= drain_d;
            busy_q      <= (state_d != StIdle);
            done_q      <= (state_d == StDone);
            w_rd_en_q   <= (state_d == StLoadW);
            w_load_en_q <= w_rd_en_q;
            i_rd_en_q   <= (state_d == StStream);
        end
    end

    // Enable and index delay lines: tap k is i_rd_en / i_rd_addr delayed k+1 cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                idx_q[k] <= '0;
            end
        end else begin
            en_q     <= {en_q[DEPTH-2:0], i_rd_en_q};
            idx_q[0] <= i_rd_en_q ? i_addr_q : '0;
            for (int k = 1; k < DEPTH; k++) begin
                idx_q[k] <= idx_q[k-1];
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign w_rd_en   = w_rd_en_q;
    assign w_rd_addr = w_addr_q;
    assign w_load_en = w_load_en_q;
    assign i_rd_en   = i_rd_en_q;
    assign i_rd_addr = i_addr_q;
    assign i_row_en  = en_q[ROWS-1:0];
    assign o_valid   = en_q[DEPTH-1:ROWS];

    for (genvar c = 0; c < COLS; c++) begin : g_idx
        assign o_vec_idx[c*VEC_W +: VEC_W] = idx_q[ROWS+c];
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl with a 4x4 array, plus a behavioural 4x4 array of
// mac PEs driven by the controller strobes for an end-to-end matrix-product check.
module tb_systolic_ctrl;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int VEC_W = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic                  skip_wload = 1'b0;
    logic [VEC_W-1:0]      num_vec = '0;
    logic                  busy, done, w_rd_en, w_load_en, i_rd_en;
    logic [1:0]            w_rd_addr;
    logic [VEC_W-1:0]      i_rd_addr;
    logic [ROWS-1:0]       i_row_en;
    logic [COLS-1:0]       o_valid;
    logic [COLS*VEC_W-1:0] o_vec_idx;

    int checks = 0;
    int passed = 0;

    systolic_ctrl #(.ROWS(ROWS), .COLS(COLS), .VEC_W(VEC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .skip_wload (skip_wload),
        .num_vec    (num_vec),
        .busy       (busy),
        .done       (done),
        .w_rd_en    (w_rd_en),
        .w_rd_addr  (w_rd_addr),
        .w_load_en  (w_load_en),
        .i_rd_en    (i_rd_en),
        .i_rd_addr  (i_rd_addr),
        .i_row_en   (i_row_en),
        .o_valid    (o_valid),
        .o_vec_idx  (o_vec_idx)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural PE array and buffers ----------------
    logic signed [7:0] wmem [ROWS][COLS];
    logic signed [7:0] xmem [16][ROWS];
    logic signed [7:0] wbuf [COLS];
    logic signed [7:0] sk   [ROWS][ROWS];
    logic signed [7:0] wpe  [ROWS][COLS];
    logic signed [7:0] xpe  [ROWS][COLS];
    logic signed [7:0] xin  [ROWS][COLS];
    int                pin  [ROWS][COLS];
    int                ppe  [ROWS][COLS];
    int                cap  [16][COLS];
    int                cap_cnt = 0;

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                xin[r][c] = '0;
                pin[r][c] = 0;
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            xin[r][0] = i_row_en[r] ? sk[r][r] : 8'sd0;
            for (int c = 1; c < COLS; c++) xin[r][c] = xpe[r][c-1];
        end
        for (int r = 1; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) pin[r][c] = ppe[r-1][c];
        end
    end

    always_ff @(posedge clk) begin
        if (w_rd_en) begin
            for (int c = 0; c < COLS; c++) wbuf[c] <= wmem[w_rd_addr][c];
        end
        for (int r = 0; r < ROWS; r++) begin
            sk[r][0] <= i_rd_en ? xmem[i_rd_addr][r] : 8'sd0;
            for (int d = 1; d < ROWS; d++) sk[r][d] <= sk[r][d-1];
        end
        if (w_load_en) begin
            for (int c = 0; c < COLS; c++) begin
                wpe[0][c] <= wbuf[c];
                for (int r = 1; r < ROWS; r++) wpe[r][c] <= wpe[r-1][c];
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                xpe[r][c] <= xin[r][c];
                ppe[r][c] <= pin[r][c] + int'(wpe[r][c]) * int'(xin[r][c]);
            end
        end
        for (int c = 0; c < COLS; c++) begin
            if (o_valid[c]) cap[o_vec_idx[c*VEC_W +: VEC_W]][c] <= ppe[ROWS-1][c];
        end
        cap_cnt <= cap_cnt + $countones(o_valid);
    end

    // ---------------- expected strobe timeline ----------------
    // Bundle layout: busy done w_rd_en w_rd_addr[1:0] w_load_en i_rd_en i_rd_addr[3:0]
    // i_row_en[3:0] o_valid[3:0] o_vec_idx[15:0]; k = cycles after the start cycle.
    function automatic logic [34:0] exp_out(input bit load, input int n, input int k);
        logic       b, d, wr, wl, ie;
        logic [1:0] wa;
        logic [3:0] ia, re, ov;
        logic [15:0] ix;
        int s0, dn;
        b = 0; d = 0; wr = 0; wl = 0; ie = 0; wa = 0; ia = 0; re = 0; ov = 0; ix = 0;
        if (n == 0) begin
            b = (k == 1);
            d = (k == 1);
        end else begin
            s0 = load ? 5 : 1;
            dn = s0 + n + 8;
            b  = (k >= 1 && k <= dn);
            d  = (k == dn);
            wr = load && k >= 1 && k <= 4;
            wa = wr ? 2'(4 - k) : 2'd0;
            wl = load && k >= 2 && k <= 5;
            ie = (k >= s0 && k < s0 + n);
            ia = ie ? 4'(k - s0) : 4'd0;
            for (int r = 0; r < 4; r++) re[r] = (k >= s0 + 1 + r && k <= s0 + n + r);
            for (int c = 0; c < 4; c++) begin
                ov[c] = (k >= s0 + 5 + c && k <= s0 + n + 4 + c);
                if (ov[c]) ix[c*4 +: 4] = 4'(k - (s0 + 5 + c));
            end
        end
        return {b, d, wr, wa, wl, ie, ia, re, ov, ix};
    endfunction

    // Addresses are only meaningful while their read strobe is expected.
    function automatic logic [34:0] snap(input logic [34:0] e);
        logic [1:0] wa;
        logic [3:0] ia;
        wa = e[32] ? w_rd_addr : 2'd0;
        ia = e[28] ? i_rd_addr : 4'd0;
        return {busy, done, w_rd_en, wa, w_load_en, i_rd_en, ia, i_row_en, o_valid, o_vec_idx};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input bit skip, input int n);
        start      = 1'b1;
        skip_wload = skip;
        num_vec    = VEC_W'(n);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [34:0] raw;
        rst = 1'b1;
        #2;
        raw = {busy, done, w_rd_en, w_rd_addr, w_load_en, i_rd_en, i_rd_addr, i_row_en,
               o_valid, o_vec_idx};
        checks++;
        if (raw !== '0) $display("FAIL reset_async got %h exp 0", raw);
        else passed++;
        tick();
        tick();
        rst = 1'b0;
        tick();
        raw = {busy, done, w_rd_en, w_rd_addr, w_load_en, i_rd_en, i_rd_addr, i_row_en,
               o_valid, o_vec_idx};
        checks++;
        if (raw !== '0) $display("FAIL reset_idle got %h exp 0", raw);
        else passed++;
    endtask

    task automatic test_full_job();
        logic [34:0] e;
        launch(0, 3);
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 1) start = 1'b0;
            e = exp_out(1, 3, k);
            checks++;
            if (snap(e) !== e) $display("FAIL full_job cyc %0d got %h exp %h", k, snap(e), e);
            else passed++;
            if (k == 1 || k == 4) begin
                checks++;
                if (w_rd_addr !== ((k == 1) ? 2'd3 : 2'd0))
                    $display("FAIL full_waddr cyc %0d got %0d", k, w_rd_addr);
                else passed++;
            end
            if (k == 15) begin
                checks++;
                if (o_valid[3] !== 1'b1 || o_vec_idx[15:12] !== 4'd2)
                    $display("FAIL full_idx3 got v=%b idx=%0d exp v=1 idx=2",
                             o_valid[3], o_vec_idx[15:12]);
                else passed++;
            end
            if (k == 16) begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b1)
                    $display("FAIL full_done got done=%b busy=%b exp 1 1", done, busy);
                else passed++;
            end
        end
    endtask

    task automatic test_skip_wload();
        logic [34:0] e;
        launch(1, 3);
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 1) start = 1'b0;
            e = exp_out(0, 3, k);
            checks++;
            if (snap(e) !== e) $display("FAIL skip_job cyc %0d got %h exp %h", k, snap(e), e);
            else passed++;
            if (k == 12) begin
                checks++;
                if (done !== 1'b1) $display("FAIL skip_done got %b exp 1", done);
                else passed++;
            end
        end
    endtask

    task automatic test_zero_vec();
        logic [34:0] e;
        launch(0, 0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) start = 1'b0;
            e = exp_out(0, 0, k);
            checks++;
            if (snap(e) !== e) $display("FAIL zero_vec cyc %0d got %h exp %h", k, snap(e), e);
            else passed++;
        end
    endtask

    task automatic test_start_held();
        logic [34:0] e;
        launch(0, 3);
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 2) num_vec = 4'd2;  // must not affect the running job
            e = exp_out(1, 3, k);
            checks++;
            if (snap(e) !== e) $display("FAIL held_job1 cyc %0d got %h exp %h", k, snap(e), e);
            else passed++;
        end
        // Cycle 17 was the IDLE cycle, so it is the start cycle of the second job.
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 1) start = 1'b0;
            e = exp_out(1, 2, k);
            checks++;
            if (snap(e) !== e) $display("FAIL held_job2 cyc %0d got %h exp %h", k, snap(e), e);
            else passed++;
        end
    endtask

    task automatic test_reset_midjob();
        logic [34:0] e;
        logic [34:0] raw;
        launch(0, 3);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        raw = {busy, done, w_rd_en, w_rd_addr, w_load_en, i_rd_en, i_rd_addr, i_row_en,
               o_valid, o_vec_idx};
        checks++;
        if (raw !== '0) $display("FAIL midjob_async got %h exp 0", raw);
        else passed++;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0)
                $display("FAIL midjob_hold got done=%b busy=%b exp 0 0", done, busy);
            else passed++;
        end
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0)
                $display("FAIL midjob_nodone got done=%b busy=%b exp 0 0", done, busy);
            else passed++;
        end
        launch(0, 3);
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 1) start = 1'b0;
            e = exp_out(1, 3, k);
            checks++;
            if (snap(e) !== e) $display("FAIL midjob_rerun cyc %0d got %h exp %h", k, snap(e), e);
            else passed++;
        end
    endtask

    task automatic test_max_vec();
        logic [34:0] e;
        launch(1, 15);
        for (int k = 1; k <= 26; k++) begin
            tick();
            if (k == 1) start = 1'b0;
            e = exp_out(0, 15, k);
            checks++;
            if (snap(e) !== e) $display("FAIL max_vec cyc %0d got %h exp %h", k, snap(e), e);
            else passed++;
            if (k == 15) begin
                checks++;
                if (i_rd_addr !== 4'd14 || i_rd_en !== 1'b1)
                    $display("FAIL max_last_addr got en=%b addr=%0d exp 1 14", i_rd_en, i_rd_addr);
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [34:0] e;
        launch(1, 3);
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 1) start = 1'b0;
            e = exp_out(0, 3, k);
            checks++;
            if (snap(e) !== e) $display("FAIL b2b_job1 cyc %0d got %h exp %h", k, snap(e), e);
            else passed++;
        end
        // Raised during DONE (ignored there), accepted in the following IDLE cycle.
        launch(0, 1);
        tick();
        checks++;
        if (busy !== 1'b0 || w_rd_en !== 1'b0)
            $display("FAIL b2b_idle got busy=%b w_rd_en=%b exp 0 0", busy, w_rd_en);
        else passed++;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 1) start = 1'b0;
            e = exp_out(1, 1, k);
            checks++;
            if (snap(e) !== e) $display("FAIL b2b_job2 cyc %0d got %h exp %h", k, snap(e), e);
            else passed++;
        end
    endtask

    task automatic test_end_to_end();
        int base;
        int refv;
        base = cap_cnt;
        launch(0, 3);
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 1) start = 1'b0;
        end
        checks++;
        if (cap_cnt - base !== 12) $display("FAIL e2e_count got %0d exp 12", cap_cnt - base);
        else passed++;
        for (int v = 0; v < 3; v++) begin
            for (int c = 0; c < COLS; c++) begin
                refv = 0;
                for (int r = 0; r < ROWS; r++) refv += int'(xmem[v][r]) * int'(wmem[r][c]);
                checks++;
                if (cap[v][c] !== refv)
                    $display("FAIL e2e_sum v%0d c%0d got %0d exp %0d", v, c, cap[v][c], refv);
                else passed++;
            end
        end
    endtask

    initial begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) wmem[r][c] = 8'(r * 3 - c * 2 + 1);
        end
        for (int v = 0; v < 16; v++) begin
            for (int r = 0; r < ROWS; r++) xmem[v][r] = (v < 3) ? 8'(v * 5 - r * 3 - 2) : 8'sd0;
        end
        test_reset();
        test_full_job();
        test_skip_wload();
        test_zero_vec();
        test_start_held();
        test_reset_midjob();
        test_max_vec();
        test_back_to_back();
        test_end_to_end();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
- Sequencer for a ROWS x COLS weight-stationary systolic array built from mac PEs.
- Per job: loads weights row by row from the weight buffer, streams num_vec input vectors with the per-row diagonal I_en skew, and generates per-column capture strobes with vector indices for the bottom-row partial sums.
- Sits between the host/job FSM and the array plus its weight, input and output buffers.
- Controls enables and addresses only; data skew registers are external.

Parameters:
- ROWS, 8, array rows (weight shift depth; input lanes).
- COLS, 8, array columns (output lanes).
- VEC_W, 16, width of vector count and index.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  job request; sampled only in IDLE.
- skip_wload  in  1  sampled with start; 1 = reuse stationary weights, skip LOAD_W.
- num_vec  in  VEC_W  number of input vectors; sampled with start.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.
- w_rd_en  out  1  weight buffer read strobe; 1-cycle read latency.
- w_rd_addr  out  clog2(ROWS)  weight buffer row address.
- w_load_en  out  1  drives W_en of all PEs.
- i_rd_en  out  1  input buffer read strobe; 1-cycle read latency.
- i_rd_addr  out  VEC_W  input vector address.
- i_row_en  out  ROWS  bit r drives I_en of row r.
- o_valid  out  COLS  bit c = bottom P_out of column c valid this cycle.
- o_vec_idx  out  COLS*VEC_W  slice c = vector index for o_valid[c].

Behaviour:
- Reset (async, any time, including mid-job): state IDLE; all outputs and every delay-line bit 0. Job is abandoned; no done pulse.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE. Registered outputs.
- IDLE: busy=0. start=1 latches num_vec and skip_wload.
  - num_vec=0: go to DONE.
  - skip_wload=1: go to STREAM.
  - Otherwise: go to LOAD_W.
- LOAD_W: exactly ROWS cycles.
  - w_rd_en=1; w_rd_addr counts ROWS-1 down to 0, so the last row loaded lands in row 0.
  - w_load_en = w_rd_en delayed 1 cycle.
  - Then go to STREAM.
- STREAM: exactly num_vec cycles.
  - i_rd_en=1; i_rd_addr counts 0..num_vec-1.
  - Then go to DRAIN.
  - The first i_row_en[0] follows the last w_load_en, so weights are settled before first use.
- Delay lines (shift registers of i_rd_en and index):
  - i_row_en[r] = i_rd_en delayed 1+r cycles.
  - o_valid[c] = i_rd_en delayed 1+ROWS+c cycles.
  - o_vec_idx[c] = i_rd_addr delayed identically to o_valid[c]; value is 0 when o_valid[c]=0.
- DRAIN: hold until the last o_valid[COLS-1] has been emitted, then go to DONE.
- DONE: one cycle; done=1, busy=1; then go to IDLE.
- busy=1 from the cycle after accepted start through the DONE cycle inclusive.
- start while not IDLE: ignored; num_vec and skip_wload changes are ignored until the next accepted start.
- w_load_en and i_row_en never overlap.
- Latency from start cycle T, with N=num_vec:
  - Full job (load): done at T+2*ROWS+COLS+N+1.
  - skip_wload=1: done at T+ROWS+COLS+N+1.
- Index counter and delay lines are VEC_W wide. num_vec = 2^VEC_W-1 must complete with no wrap before the last address.
- A new start is accepted in the IDLE cycle immediately after DONE (back-to-back jobs).

Test Plan:
- ROWS=COLS=4, num_vec=3, skip_wload=0, start at cycle 0:
  - w_rd_en cycles 1-4, addr 3,2,1,0; w_load_en cycles 2-5.
  - i_rd_en cycles 5-7, addr 0,1,2.
  - i_row_en[0] cycles 6-8; i_row_en[3] cycles 9-11.
  - o_valid[0] cycles 10-12; o_valid[3] cycles 13-15, idx 0,1,2.
  - done at cycle 16.
- Same config with skip_wload=1: no w_rd_en or w_load_en; i_rd_en cycles 1-3; done at cycle 12.
- num_vec=0: busy=1 and done=1 at cycle 1; no other strobes ever assert.
- start held high through a whole job: exactly one job runs; second job's w_rd_en starts 2 cycles after done (IDLE cycle, then LOAD_W).
- rst asserted at cycle 8 of the first scenario:
  - All outputs 0 asynchronously, before the next clock edge.
  - No done pulse.
  - A fresh start after release reproduces the first-scenario timing.
- End-to-end: 4x4 array of mac PEs with known signed weights and inputs; captured bottom-row sums equal the reference matrix product for all 3 vectors.
